// File: rtl/sr_func_calc.sv
// Purpose : multi-cycle HYP function unit, y = a^3 + floor(sqrt(b)), 24-bit result.
// Latency : busy_o high 21 cycles (serial multiply) or 7 cycles (SR_CALC_FAST_MUL_EN).
// Backpressure: start is a level request taken only in IDLE; ignored while busy and during DONE guard.
//
// Ports:
//   clk    - clock, all state on rising edge
//   rst_n  - asynchronous active-low reset; aborts any operation in flight
//   a, b   - 8-bit operands, sampled only when start is accepted
//   start  - level request, accepted only in IDLE
//   y      - 24-bit result, updated only in FIN, held otherwise
//   busy_o - high from the edge after start is accepted until y is written
//
// Build option: define SR_CALC_FAST_MUL_EN to replace the two 8-cycle shift-add
// multiply phases with single-cycle combinational multiplies. Results are identical.
// DONE_CYCLES must lie in 1..8 because it is loaded into the shared 3-bit counter.

module sr_func_calc #(
    parameter logic [23:0] Y_RESET     = 24'h000000,
    parameter int          DONE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic        start,
    output logic [23:0] y,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SQRT = 3'd1,
        MUL1 = 3'd2,
        MUL2 = 3'd3,
        FIN  = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam logic [2:0] DONE_LOAD = 3'(DONE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q,   cnt_d;
    logic [7:0]  a_q,     a_d;
    logic [7:0]  b_q,     b_d;      // shifts left two bits per SQRT cycle
    logic [3:0]  root_q,  root_d;
    logic [8:0]  rem_q,   rem_d;
    logic [15:0] sq_q,    sq_d;
    logic [23:0] cube_q,  cube_d;
    logic [23:0] y_q,     y_d;
    logic        busy_q,  busy_d;

    // Bit-serial square root: bring down the next bit pair of b, then try
    // subtracting (4*root + 1), which is the cost of setting the next root bit.
    logic [8:0]  rem_shift;
    logic [8:0]  sqrt_trial;
    logic        sqrt_fit;

    assign rem_shift  = (rem_q << 2) | {7'd0, b_q[7:6]};
    assign sqrt_trial = {3'd0, root_q, 2'b01};
    assign sqrt_fit   = (rem_shift >= sqrt_trial);

`ifdef SR_CALC_FAST_MUL_EN
    logic [15:0] sq_prod;
    logic [23:0] cube_prod;

    assign sq_prod   = {8'd0, a_q} * {8'd0, a_q};
    assign cube_prod = {8'd0, sq_q} * {16'd0, a_q};
`else
    // Shift-add multiplier shared by MUL1 (a*a) and MUL2 (sq*a). The
    // multiplicand moves left and the multiplier right, LSB first.
    logic [23:0] mcand_q,  mcand_d;
    logic [7:0]  mplier_q, mplier_d;
    logic [15:0] sq_nxt;
    logic [23:0] cube_nxt;

    assign sq_nxt   = sq_q   + (mplier_q[0] ? mcand_q[15:0] : 16'd0);
    assign cube_nxt = cube_q + (mplier_q[0] ? mcand_q       : 24'd0);
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        root_d   = root_q;
        rem_d    = rem_q;
        sq_d     = sq_q;
        cube_d   = cube_q;
        y_d      = y_q;
        busy_d   = busy_q;
`ifndef SR_CALC_FAST_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    root_d  = 4'd0;
                    rem_d   = 9'd0;
                    sq_d    = 16'd0;
                    cube_d  = 24'd0;
                    cnt_d   = 3'd3;
                    busy_d  = 1'b1;
                    state_d = SQRT;
`ifndef SR_CALC_FAST_MUL_EN
                    mcand_d  = {16'd0, a};
                    mplier_d = a;
`endif
                end
            end
            SQRT: begin
                b_d = b_q << 2;
                if (sqrt_fit) begin
                    rem_d  = rem_shift - sqrt_trial;
                    root_d = {root_q[2:0], 1'b1};
                end else begin
                    rem_d  = rem_shift;
                    root_d = {root_q[2:0], 1'b0};
                end
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd0) begin
                    cnt_d   = 3'd7;
                    state_d = MUL1;
                end
            end
            MUL1: begin
`ifdef SR_CALC_FAST_MUL_EN
                sq_d    = sq_prod;
                state_d = MUL2;
`else
                sq_d     = sq_nxt;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 3'd1;
                if (cnt_q == 3'd0) begin
                    // Re-arm the multiplier for sq*a using the final square.
                    mcand_d  = {8'd0, sq_nxt};
                    mplier_d = a_q;
                    cnt_d    = 3'd7;
                    state_d  = MUL2;
                end
`endif
            end
            MUL2: begin
`ifdef SR_CALC_FAST_MUL_EN
                cube_d  = cube_prod;
                state_d = FIN;
`else
                cube_d   = cube_nxt;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 3'd1;
                if (cnt_q == 3'd0) begin
                    state_d = FIN;
                end
`endif
            end
            FIN: begin
                y_d     = cube_q + {20'd0, root_q};
                busy_d  = 1'b0;
                cnt_d   = DONE_LOAD;
                state_d = DONE;
            end
            DONE: begin
                // Guard window: lets the stalled core advance before a held start re-triggers.
                if (cnt_q == 3'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            a_q     <= 8'd0;
            b_q     <= 8'd0;
            root_q  <= 4'd0;
            rem_q   <= 9'd0;
            sq_q    <= 16'd0;
            cube_q  <= 24'd0;
            y_q     <= Y_RESET;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            root_q  <= root_d;
            rem_q   <= rem_d;
            sq_q    <= sq_d;
            cube_q  <= cube_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
        end
    end

`ifndef SR_CALC_FAST_MUL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= 24'd0;
            mplier_q <= 8'd0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end
`endif

    assign y      = y_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_sr_func_calc.sv
// Purpose : self-checking bench for sr_func_calc against a behavioural model.
// Latency : checks busy_o length (21, or 7 with SR_CALC_FAST_MUL_EN) and DONE guard gap.
// Backpressure: exercises ignored start while busy, mid-op reset and start held high.

module tb_sr_func_calc;

    localparam int DC = 1;
`ifdef SR_CALC_FAST_MUL_EN
    localparam int BUSY_CYC = 7;
`else
    localparam int BUSY_CYC = 21;
`endif

    logic        clk;
    logic        rst_n;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        start;
    logic [23:0] y;
    logic        busy_o;

    int n_checks = 0;
    int n_errors = 0;

    sr_func_calc #(
        .Y_RESET     (24'h000000),
        .DONE_CYCLES (DC)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .start  (start),
        .y      (y),
        .busy_o (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: integer cube plus integer square root by search.
    function automatic longint ref_y(input int av, input int bv);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= bv) r++;
        return longint'(av) * av * av + r;
    endfunction

    // Issue one op with a single-cycle start pulse, measure busy length,
    // check result, then wait out the guard window.
    task automatic run_op(input string tag, input int av, input int bv);
        int cnt;
        @(negedge clk);
        a = 8'(av);
        b = 8'(bv);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        cnt = 0;
        while (busy_o && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check({tag, "_busy"}, cnt, BUSY_CYC);
        check({tag, "_y"}, y, ref_y(av, bv));
        repeat (DC) @(negedge clk);
    endtask

    initial begin
        int cnt;
        int falls;
        logic prev;

        rst_n = 1'b0;
        a = 8'd0;
        b = 8'd0;
        start = 1'b0;
        #12;
        check("rst_busy", busy_o, 0);
        check("rst_y", y, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // T1 / T2 directed values
        run_op("t1", 3, 16);
        check("t1_val", y, 24'h00001F);
        repeat (5) @(negedge clk);
        check("t1_hold", y, 24'h00001F);
        run_op("t2_max", 255, 255);
        check("t2_val", y, 24'hFD030E);
        run_op("t2_00", 0, 0);
        run_op("t2_01", 0, 1);
        run_op("t2_13", 1, 3);

        // T3: second request while busy must be ignored
        @(negedge clk);
        a = 8'd4; b = 8'd25; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        a = 8'd9; b = 8'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        falls = 0;
        prev = busy_o;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (prev && !busy_o) falls++;
            prev = busy_o;
        end
        check("t3_y", y, 69);
        check("t3_falls", falls, 1);
        check("t3_idle", busy_o, 0);

        // T4: asynchronous reset mid-operation
        @(negedge clk);
        a = 8'd5; b = 8'd49; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("t4_busy_before", busy_o, 1);
        rst_n = 1'b0;
        #1;
        check("t4_rst_busy", busy_o, 0);
        check("t4_rst_y", y, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("t4_abort_y", y, 0);
        check("t4_abort_busy", busy_o, 0);
        run_op("t4_after", 2, 9);
        check("t4_val", y, 11);

        // T5: start held high -> back-to-back ops with fixed gap
        @(negedge clk);
        a = 8'd1; b = 8'd4; start = 1'b1;
        cnt = 0;
        while (!busy_o && cnt < 10) begin
            cnt++;
            @(negedge clk);
        end
        check("t5_rise", busy_o, 1);
        for (int k = 0; k < 3; k++) begin
            cnt = 0;
            while (busy_o && cnt < 100) begin
                cnt++;
                @(negedge clk);
            end
            check("t5_busy", cnt, BUSY_CYC);
            check("t5_y", y, 3);
            cnt = 0;
            while (!busy_o && cnt < 20) begin
                cnt++;
                @(negedge clk);
            end
            check("t5_gap", cnt, DC + 1);
        end
        start = 1'b0;
        cnt = 0;
        while (busy_o && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        repeat (DC + 2) @(negedge clk);

        // Random operands against the reference model
        for (int k = 0; k < 16; k++) begin
            run_op("rand", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
